// File: rtl/uart_tx_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
// Register byte offsets within the 16-byte window, STATUS bit positions and the TX FSM states.
package uart_tx_pkg;

    localparam logic [3:0] TXDATA_OFF = 4'h0;
    localparam logic [3:0] STATUS_OFF = 4'h4;
    localparam logic [3:0] DIV_OFF    = 4'h8;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_ACTIVE  = 2;
    localparam int ST_CNT_LSB = 4;
    localparam int ST_CNT_MSB = 7;
    localparam int ST_OVF     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO: head visible combinationally on pop_dat, one-cycle write-to-read.
// A push while full is dropped and a pop while empty is ignored; fullness is judged before the edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign pop_dat = mem[rd_ptr];

    // Storage needs no reset; validity is tracked entirely by count and the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: combinational reads, register writes visible next cycle.
// TXDATA pushes into a small FIFO; pushes while full are dropped and flag sticky overflow.
module mmio_uart_tx
    import uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] a_i,
    input  logic [31:0] wd_i,
    input  logic        we_i,
    input  logic [3:0]  wmask_i,
    output logic [31:0] rd_o,
    output logic        sel_o,
    output logic        tx_o,
    output logic        busy_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [3:0]    off;
    logic          wr_en;
    logic          push;
    logic          ovf_clr;
    logic [15:0]   div_r;
    logic [15:0]   div_eff;
    logic          ovf_r;
    logic [31:0]   status;

    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_cnt;
    logic [CW-1:0] cnt_nxt;
    logic [7:0]    fifo_dat;
    logic          pop;

    tx_state_t     state, state_d;
    logic [15:0]   cnt, cnt_d;
    logic [2:0]    bit_idx, bit_d;
    logic [7:0]    shift, shift_d;
    logic [15:0]   div_q, divq_d;
    logic          tx_d;

    logic          unused_bits;
    assign unused_bits = ^{wd_i[31:16], wmask_i[3:2]};

    assign sel_o   = (a_i[31:4] == BASE_ADDR[31:4]);
    assign off     = {a_i[3:2], 2'b00};
    assign wr_en   = we_i & sel_o & (a_i[1:0] == 2'b00);
    assign push    = wr_en & (off == TXDATA_OFF) & wmask_i[0];
    assign ovf_clr = wr_en & (off == STATUS_OFF) & wmask_i[1] & wd_i[8];
    assign div_eff = (div_r == 16'd0) ? 16'd1 : div_r;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk_i),
        .rst      (rst_i),
        .push     (push),
        .push_dat (wd_i[7:0]),
        .pop      (pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

    always_comb begin
        status                         = '0;
        status[ST_FULL]                = fifo_full;
        status[ST_EMPTY]               = fifo_empty;
        status[ST_ACTIVE]              = (state != IDLE);
        status[ST_CNT_MSB:ST_CNT_LSB]  = 4'(fifo_cnt);
        status[ST_OVF]                 = ovf_r;
    end

    always_comb begin
        rd_o = '0;
        if (sel_o) begin
            case (off)
                STATUS_OFF: rd_o = status;
                DIV_OFF:    rd_o = {16'h0000, div_r};
                default:    rd_o = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_r <= DEFAULT_DIV;
            ovf_r <= 1'b0;
        end else begin
            if (wr_en && off == DIV_OFF) begin
                if (wmask_i[0]) div_r[7:0]  <= wd_i[7:0];
                if (wmask_i[1]) div_r[15:8] <= wd_i[15:8];
            end
            if (push && fifo_full) begin
                ovf_r <= 1'b1;
            end else if (ovf_clr) begin
                ovf_r <= 1'b0;
            end
        end
    end

    // Bit timer reloads with div_q-1 and the bit advances on the edge where it hits 0.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        bit_d   = bit_idx;
        shift_d = shift;
        divq_d  = div_q;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dat;
                    divq_d  = div_eff;
                    cnt_d   = div_eff - 16'd1;
                    bit_d   = 3'd0;
                    state_d = START;
                end
            end
            START: begin
                if (cnt == 16'd0) begin
                    cnt_d   = div_q - 16'd1;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt - 16'd1;
                end
            end
            DATA: begin
                if (cnt == 16'd0) begin
                    cnt_d = div_q - 16'd1;
                    if (bit_idx == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_idx + 3'd1;
                        shift_d = {1'b0, shift[7:1]};
                    end
                end else begin
                    cnt_d = cnt - 16'd1;
                end
            end
            STOP: begin
                if (cnt == 16'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The line is registered from the current state, so it trails the FSM by one cycle.
    always_comb begin
        case (state)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift[0];
            default: tx_d = 1'b1;
        endcase
    end

    assign cnt_nxt = fifo_cnt + CW'(push & ~fifo_full) - CW'(pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            div_q   <= '0;
            tx_o    <= 1'b1;
            busy_o  <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            bit_idx <= bit_d;
            shift   <= shift_d;
            div_q   <= divq_d;
            tx_o    <= tx_d;
            busy_o  <= (state_d != IDLE) || (cnt_nxt != '0);
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register access, 8N1 framing, FIFO overflow, masks, decode, reset.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] a_i;
    logic [31:0] wd_i;
    logic        we_i;
    logic [3:0]  wmask_i;
    logic [31:0] rd_o;
    logic        sel_o;
    logic        tx_o;
    logic        busy_o;

    int tests = 0;
    int fails = 0;

    always #5 clk_i = ~clk_i;

    mmio_uart_tx #(
        .BASE_ADDR   (BASE),
        .FIFO_DEPTH  (4),
        .DEFAULT_DIV (16'd16)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .a_i     (a_i),
        .wd_i    (wd_i),
        .we_i    (we_i),
        .wmask_i (wmask_i),
        .rd_o    (rd_o),
        .sel_o   (sel_o),
        .tx_o    (tx_o),
        .busy_o  (busy_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
        @(negedge clk_i);
        a_i     = addr;
        wd_i    = data;
        wmask_i = mask;
        we_i    = 1'b1;
        @(posedge clk_i);
        #1;
        we_i    = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] v, output logic s);
        @(negedge clk_i);
        a_i  = addr;
        we_i = 1'b0;
        #1;
        v = rd_o;
        s = sel_o;
    endtask

    initial begin
        logic [31:0] v;
        logic        s;
        logic [9:0]  frame;
        logic        seen_low;
        int          n;

        rst_i   = 1'b1;
        a_i     = '0;
        wd_i    = '0;
        we_i    = 1'b0;
        wmask_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Reset state
        chk("rst_tx", tx_o, 1);
        chk("rst_busy", busy_o, 0);
        rd(BASE + 32'h4, v, s);
        chk("rst_status", v, 32'h0000_0002);
        chk("rst_sel_base", s, 1);
        rd(BASE + 32'h8, v, s);
        chk("rst_div", v, 32'h0000_0010);
        rd(32'h0, v, s);
        chk("rst_sel_zero", s, 0);
        chk("rst_rd_zero", v, 0);
        rd(BASE + 32'hC, v, s);
        chk("reserved_rd", v, 0);

        // DIV=4, 0x55 framed as 0,1,0,1,... each bit 4 cycles, first low two edges after push
        wr(BASE + 32'h8, 32'h4, 4'b0011);
        rd(BASE + 32'h8, v, s);
        chk("div4_rd", v, 32'h4);
        wr(BASE + 32'h0, 32'h55, 4'b0001);
        frame = {1'b1, 8'h55, 1'b0};
        for (int k = 1; k <= 41; k++) begin
            @(posedge clk_i);
            #1;
            chk($sformatf("f55_tx_k%0d", k), tx_o, (k < 2) ? 1'b1 : frame[(k-2)/4]);
            if (k == 40) chk("f55_busy_k40", busy_o, 1);
        end
        chk("f55_busy_end", busy_o, 0);

        // DIV=16, six back-to-back pushes: one in shifter, four queued, sixth dropped
        wr(BASE + 32'h8, 32'h10, 4'b0011);
        for (int i = 0; i < 6; i++) wr(BASE + 32'h0, 32'hA0 + i, 4'b0001);
        rd(BASE + 32'h4, v, s);
        chk("ovf_status", v, 32'h0000_0145);
        wr(BASE + 32'h4, 32'h100, 4'b0010);
        rd(BASE + 32'h4, v, s);
        chk("ovf_cleared", v, 32'h0000_0045);
        n = 0;
        while (busy_o && n < 3000) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        chk("drain_busy", busy_o, 0);
        rd(BASE + 32'h4, v, s);
        chk("drain_status", v, 32'h0000_0002);

        // Mask handling
        wr(BASE + 32'h0, 32'h77, 4'b1110);
        rd(BASE + 32'h4, v, s);
        chk("mask_nopush_status", v, 32'h0000_0002);
        chk("mask_nopush_busy", busy_o, 0);
        wr(BASE + 32'h8, 32'hABCD, 4'b0001);
        rd(BASE + 32'h8, v, s);
        chk("div_lane0", v, 32'h0000_00CD);
        wr(BASE + 32'h8, 32'h0, 4'b0011);
        rd(BASE + 32'h8, v, s);
        chk("div_zero_rd", v, 0);
        wr(BASE + 32'h0, 32'h01, 4'b0001);
        frame = {1'b1, 8'h01, 1'b0};
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk_i);
            #1;
            chk($sformatf("div0_tx_k%0d", k), tx_o, (k < 2) ? 1'b1 : frame[k-2]);
        end
        chk("div0_busy_end", busy_o, 0);

        // Out-of-window access
        rd(BASE + 32'h10, v, s);
        chk("oow_sel", s, 0);
        chk("oow_rd", v, 0);
        wr(BASE + 32'h10, 32'h12, 4'b1111);
        chk("oow_busy", busy_o, 0);
        rd(BASE + 32'h8, v, s);
        chk("oow_div_kept", v, 0);
        rd(BASE + 32'h4, v, s);
        chk("oow_status_kept", v, 32'h0000_0002);

        // Reset mid-DATA with two bytes queued
        wr(BASE + 32'h8, 32'h4, 4'b0011);
        wr(BASE + 32'h0, 32'hA1, 4'b0001);
        wr(BASE + 32'h0, 32'hA2, 4'b0001);
        wr(BASE + 32'h0, 32'hA3, 4'b0001);
        repeat (8) @(posedge clk_i);
        rd(BASE + 32'h4, v, s);
        chk("pre_rst_status", v, 32'h0000_0024);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        chk("mid_rst_tx", tx_o, 1);
        chk("mid_rst_busy", busy_o, 0);
        rd(BASE + 32'h4, v, s);
        chk("mid_rst_status", v, 32'h0000_0002);
        rd(BASE + 32'h8, v, s);
        chk("mid_rst_div", v, 32'h0000_0010);
        seen_low = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk_i);
            #1;
            if (!tx_o || busy_o) seen_low = 1'b1;
        end
        chk("post_rst_quiet", seen_low, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter that acts as a responder on the core's data-memory port (address, write data, write enable, byte write mask, read data). It decodes a 16-byte window, accepts byte pushes into a small TX FIFO and serialises them 8N1 on `tx_o` at a programmable bit period. Reads are combinational because the single-cycle core samples load data in the same cycle it drives the address. The top level muxes `rd_o` into the core's load data when `sel_o` is high, and the data RAM's data otherwise.

## Interface
- `BASE_ADDR`, 32'h0000_1000, window base; must be 16-byte aligned.
- `FIFO_DEPTH`, 4, TX FIFO entries; power of two, at least 2.
- `DEFAULT_DIV`, 16'd16, reset value of DIV, in clocks per bit.

Ports:
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `a_i`  in  32  byte address from the core's data port.
- `wd_i`  in  32  store data.
- `we_i`  in  1  store enable.
- `wmask_i`  in  4  byte lane enables; bit n enables `wd_i[8n+7:8n]`.
- `rd_o`  out  32  combinational read data; 0 when `sel_o`=0.
- `sel_o`  out  1  combinational; 1 iff `a_i[31:4]==BASE_ADDR[31:4]`.
- `tx_o`  out  1  serial line, registered, idle high.
- `busy_o`  out  1  registered; 1 when the FSM is not IDLE or the FIFO is not empty.

## Operation
- Register map (byte offset `a_i[3:2]`):
  - 0x0 TXDATA: write pushes `wd_i[7:0]` when `wmask_i[0]`=1; reads 0.
  - 0x4 STATUS: read-only except bit 8.
    - bit0 full, bit1 empty, bit2 shifter active (FSM not IDLE).
    - [7:4] FIFO count, bit8 overflow (sticky).
    - A write with `wmask_i[1]`=1 and `wd_i[8]`=1 clears overflow.
  - 0x8 DIV: [15:0] R/W per byte lane (mask bits 0,1); upper bits read 0. A stored 0 is treated as 1.
  - 0xC: reserved; reads 0, writes ignored.
- A write is effective only when `we_i & sel_o`. Unaligned `a_i[1:0]` is ignored.
- Push to a full FIFO: the byte is dropped and overflow is set. Fullness is judged on the count before the edge, even if a pop happens in the same cycle.
- Simultaneous push and pop on a non-full FIFO: count is unchanged and both take effect.
- TX FSM states: IDLE → START → DATA → STOP → IDLE.
  - IDLE: `tx_o`=1. If count>0 before the edge, pop into the shifter, latch DIV into `div_q`, and go to START.
  - START: `tx_o`=0 for `div_q` cycles.
  - DATA: 8 bits, LSB first, each held `div_q` cycles; bit index 0..7.
  - STOP: `tx_o`=1 for `div_q` cycles, then IDLE.
- Writing DIV mid-frame does not affect the current frame.
- Reset values: `tx_o`=1, `busy_o`=0, FSM IDLE, FIFO empty, overflow=0, DIV=`DEFAULT_DIV`. `rd_o`/`sel_o` are purely combinational from `a_i` and state.
- Reset asserted mid-frame: at the next edge `tx_o`=1, the FIFO is flushed and the partial frame is abandoned.

## Timing
- Register writes are visible on reads in the cycle after the write edge.
- Push at edge N, FIFO previously empty, FSM IDLE:
  - edge N+1: pop.
  - from edge N+2: `tx_o`=0.
  - A frame occupies 10×`div_q` cycles.
- Back-to-back frames are separated by exactly one IDLE cycle (`tx_o`=1).
- The bit counter counts `div_q`-1 down to 0. The bit advances on the edge where it reaches 0.
- `busy_o` falls on the edge entering IDLE with the FIFO empty.

## Structure
- Package `uart_tx_pkg` holds:
  - register offset constants `TXDATA_OFF`, `STATUS_OFF`, `DIV_OFF`;
  - STATUS bit positions;
  - the `tx_state_t` enum (IDLE, START, DATA, STOP).
- Sub-module `sync_fifo`, parameterised on WIDTH and DEPTH, with push/pop/full/empty/count. It is reusable for a later receiver.
- The top holds address decode, the register file and the TX FSM.

## Test plan
1. Reset → STATUS reads 32'h0000_0002, DIV reads 32'h0000_0010, `tx_o`=1, `busy_o`=0, `sel_o`=0 at address 0x0.
2. DIV=4, write 0x55 to TXDATA → `tx_o` sequence 0,1,0,1,0,1,0,1,0,1, each bit held 4 cycles (40 cycles total, first low 2 cycles after the write edge); then `busy_o`=0.
3. DIV=16, six consecutive TXDATA writes → the first is popped into the shifter, 2–5 fill the FIFO, and the sixth is dropped. STATUS then reads full=1, count=4, overflow=1. Writing 0x100 with mask 4'b0010 clears overflow.
4. Mask handling:
   - TXDATA write with mask 4'b1110 → no push.
   - DIV write of 0xABCD with mask 4'b0001 from DIV=0x0010 → DIV reads 0x00CD.
   - DIV=0 → frame bits last 1 cycle.
5. Store to `BASE_ADDR`+0x10 → `sel_o`=0, `rd_o`=0, no state change.
6. Assert `rst_i` for 1 cycle mid-DATA with 2 bytes queued → next edge `tx_o`=1, STATUS=0x2, no further frames.
